asteroid_spawner: RTL

- Consumer end of the asteroid fire interface: it takes the fire pulse stream from the asteroid controller and turns each fire event into an actual asteroid.
- It owns a fixed pool of asteroid slots. Each spawn allocates a free slot and takes its x position and speed from the RNG word.
- Active asteroids advance downward once per frame tick. A slot is released on leaving the screen or on a hit report from collision logic.
- Slot state feeds the VGA renderer and collision detector.

---
 rtl/asteroid_pkg.sv | 14 +
 rtl/asteroid_spawner_if.sv | 26 ++
 rtl/asteroid_spawner_free_slot_finder.sv | 21 ++
 rtl/asteroid_spawner.sv | 95 +++++++++
 4 files changed

// File: rtl/asteroid_pkg.sv
// asteroid_pkg: shared screen geometry and asteroid speed encoding
package asteroid_pkg;
    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPEED_W  = 3;

    typedef logic [SPEED_W-1:0] speed_t;

    // two RNG bits pick 0..3, biased up so every asteroid moves 1..4 pixels per frame
    function automatic speed_t rand_speed(input logic [1:0] r);
        return {1'b0, r} + speed_t'(1);
    endfunction
endpackage

// File: rtl/asteroid_spawner_if.sv
// asteroid_spawner_if: fire/hit event inputs and slot state outputs of the asteroid spawner
interface asteroid_spawner_if #(
    parameter int NUM_SLOTS = 8,
    parameter int COORD_W   = asteroid_pkg::COORD_W
);
    logic                         fire_in;
    logic [15:0]                  rand_in;
    logic                         frame_tick;
    logic                         hit_valid;
    logic [3:0]                   hit_slot;
    logic [NUM_SLOTS-1:0]         ast_active;
    logic [NUM_SLOTS*COORD_W-1:0] ast_x;
    logic [NUM_SLOTS*COORD_W-1:0] ast_y;
    logic                         spawn_ack;
    logic [7:0]                   drop_count;

    modport master (
        output fire_in, rand_in, frame_tick, hit_valid, hit_slot,
        input  ast_active, ast_x, ast_y, spawn_ack, drop_count
    );

    modport slave (
        input  fire_in, rand_in, frame_tick, hit_valid, hit_slot,
        output ast_active, ast_x, ast_y, spawn_ack, drop_count
    );
endinterface

// File: rtl/asteroid_spawner_free_slot_finder.sv
// free_slot_finder: index of the lowest clear bit in a busy mask, plus an any-free flag
module free_slot_finder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] busy,
    output logic [W-1:0] idx,
    output logic         any_free
);
    // scan from the top down so the lowest free index is the last one written
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (!busy[k]) begin
                idx      = W'(k);
                any_free = 1'b1;
            end
        end
    end
endmodule

// File: rtl/asteroid_spawner.sv
// asteroid_spawner: asteroid slot pool filled by fire edges, advanced per frame, freed on exit or hit
module asteroid_spawner #(
    parameter int NUM_SLOTS = 8,
    parameter int COORD_W   = asteroid_pkg::COORD_W,
    parameter int SCREEN_W  = asteroid_pkg::SCREEN_W,
    parameter int SCREEN_H  = asteroid_pkg::SCREEN_H
) (
    input logic               clk,
    input logic               rst,
    asteroid_spawner_if.slave bus
);
    import asteroid_pkg::*;

    localparam int SLOT_W = $clog2(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] active;
    logic [COORD_W-1:0]   x [NUM_SLOTS];
    logic [COORD_W-1:0]   y [NUM_SLOTS];
    speed_t               speed [NUM_SLOTS];
    logic [COORD_W:0]     ny [NUM_SLOTS];
    logic                 spawn_ack;
    logic [7:0]           drop_count;
    logic                 fire_q;
    logic                 fire_rise;
    logic [SLOT_W-1:0]    free_idx;
    logic                 any_free;
    logic [SLOT_W-1:0]    hit_idx;
    logic [9:0]           rx;
    logic [COORD_W-1:0]   spawn_x;
    logic                 unused_bits;

    free_slot_finder #(.N(NUM_SLOTS), .W(SLOT_W)) finder (
        .busy    (active),
        .idx     (free_idx),
        .any_free(any_free)
    );

    assign fire_rise   = bus.fire_in & ~fire_q;
    assign hit_idx     = bus.hit_slot[SLOT_W-1:0];
    assign rx          = bus.rand_in[9:0];
    // a single fold is enough: the largest 10-bit value minus the width is already on screen
    assign spawn_x     = COORD_W'(rx < 10'(SCREEN_W) ? rx : rx - 10'(SCREEN_W));
    assign unused_bits = ^{bus.rand_in[15:12], bus.hit_slot};

    // next y of every slot, one bit wider so the exit compare cannot wrap
    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            ny[k] = {1'b0, y[k]} + (COORD_W + 1)'(speed[k]);
        end
    end

    // pool update: a spawn claims a slot free at the start of the cycle, hits beat frame advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active     <= '0;
            fire_q     <= 1'b0;
            spawn_ack  <= 1'b0;
            drop_count <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                x[k]     <= '0;
                y[k]     <= '0;
                speed[k] <= '0;
            end
        end else begin
            fire_q    <= bus.fire_in;
            spawn_ack <= fire_rise & any_free;
            if (fire_rise && !any_free && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (fire_rise && any_free && free_idx == SLOT_W'(k)) begin
                    active[k] <= 1'b1;
                    x[k]      <= spawn_x;
                    y[k]      <= '0;
                    speed[k]  <= rand_speed(bus.rand_in[11:10]);
                end else if (active[k] && ((bus.hit_valid && hit_idx == SLOT_W'(k)) ||
                             (bus.frame_tick && ny[k] >= (COORD_W + 1)'(SCREEN_H)))) begin
                    active[k] <= 1'b0;
                    y[k]      <= '0;
                end else if (active[k] && bus.frame_tick) begin
                    y[k] <= ny[k][COORD_W-1:0];
                end
            end
        end
    end

    assign bus.ast_active = active;
    assign bus.spawn_ack  = spawn_ack;
    assign bus.drop_count = drop_count;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_out
        assign bus.ast_x[s*COORD_W +: COORD_W] = x[s];
        assign bus.ast_y[s*COORD_W +: COORD_W] = y[s];
    end
endmodule
